// File: rtl/image_gradient.sv
// image_gradient: central-difference X/Y gradient over a WIDTH x HEIGHT image.
// Each pixel reads its four neighbours (L, R, U, D) from a 2-cycle-latency BRAM.
// It then writes (R-L)/2 and (D-U)/2 as two's-complement words.
// Optional macro GRADIENT_EDGE_CLAMP_EN: when defined, border pixels use
// edge-clamped neighbours. When undefined, border gradients are forced to zero.
module image_gradient #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int BIT_DEPTH = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    img_read_addr,
  output logic                               img_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]               img_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    x_write_addr,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    y_write_addr,
  output logic [BIT_DEPTH-1:0]               x_pixel_out,
  output logic [BIT_DEPTH-1:0]               y_pixel_out,
  output logic                               x_write_valid,
  output logic                               y_write_valid,
  output logic                               busy_out,
  output logic                               done_out
);

  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [2:0] {IDLE, READ_L, READ_R, READ_U, READ_D, WRITE, DONE} state_t;

  state_t                      state, state_next;
  logic [1:0]                  phase;
  logic [XW-1:0]               x, nx;
  logic [YW-1:0]               y, ny;
  logic [BIT_DEPTH-1:0]        l_pix, r_pix, u_pix, d_pix;
  logic signed [BIT_DEPTH-1:0] gx, gy;
  logic                        read_state, last_pixel;

  function automatic logic [AW-1:0] to_addr(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
    return AW'(cy) * AW'(WIDTH) + AW'(cx);
  endfunction

  // Difference at BIT_DEPTH+1 bits, arithmetic halve, truncate; the halved range always fits.
  function automatic logic signed [BIT_DEPTH-1:0] half_diff(input logic [BIT_DEPTH-1:0] a,
                                                            input logic [BIT_DEPTH-1:0] b);
    logic signed [BIT_DEPTH:0] diff, shifted;
    diff    = $signed({1'b0, a}) - $signed({1'b0, b});
    shifted = diff >>> 1;
    return shifted[BIT_DEPTH-1:0];
  endfunction

  assign read_state = (state == READ_L) || (state == READ_R) ||
                      (state == READ_U) || (state == READ_D);
  assign last_pixel = (x == X_LAST) && (y == Y_LAST);
  assign gx         = half_diff(r_pix, l_pix);
  assign gy         = half_diff(d_pix, u_pix);

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  // Read-phase counter and raster position; restart from pixel 0 on start
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      phase <= 2'd0;
      x     <= '0;
      y     <= '0;
    end else begin
      if (read_state) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      else            phase <= 2'd0;
      if (state == IDLE && start_in) begin
        x <= '0;
        y <= '0;
      end else if (state == WRITE) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= last_pixel ? '0 : y + Y_ONE;
        end else begin
          x <= x + X_ONE;
        end
      end
    end
  end

  // Neighbour capture: the BRAM word is valid in the third cycle of each read
  always_ff @(posedge clk_in) begin
    if (phase == 2'd2) begin
      case (state)
        READ_L:  l_pix <= img_pixel_in;
        READ_R:  r_pix <= img_pixel_in;
        READ_U:  u_pix <= img_pixel_in;
        READ_D:  d_pix <= img_pixel_in;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = READ_L;
      READ_L:  if (phase == 2'd2) state_next = READ_R;
      READ_R:  if (phase == 2'd2) state_next = READ_U;
      READ_U:  if (phase == 2'd2) state_next = READ_D;
      READ_D:  if (phase == 2'd2) state_next = WRITE;
      WRITE:   state_next = last_pixel ? DONE : READ_L;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: edge-clamped neighbour addressing, strobes and gated gradient words
  always_comb begin
    nx                  = x;
    ny                  = y;
    img_read_addr       = '0;
    img_read_addr_valid = 1'b0;
    x_write_addr        = '0;
    y_write_addr        = '0;
    x_pixel_out         = '0;
    y_pixel_out         = '0;
    x_write_valid       = 1'b0;
    y_write_valid       = 1'b0;
    busy_out            = (state != IDLE) && (state != DONE);
    done_out            = (state == DONE);
    case (state)
      READ_L:  nx = (x == '0)     ? x : x - X_ONE;
      READ_R:  nx = (x == X_LAST) ? x : x + X_ONE;
      READ_U:  ny = (y == '0)     ? y : y - Y_ONE;
      READ_D:  ny = (y == Y_LAST) ? y : y + Y_ONE;
      default: ;
    endcase
    if (read_state) begin
      img_read_addr       = to_addr(nx, ny);
      img_read_addr_valid = (phase == 2'd0);
    end
    if (state == WRITE) begin
      x_write_addr  = to_addr(x, y);
      y_write_addr  = to_addr(x, y);
      x_write_valid = 1'b1;
      y_write_valid = 1'b1;
      x_pixel_out   = gx;
      y_pixel_out   = gy;
`ifndef GRADIENT_EDGE_CLAMP_EN
      if (x == '0 || x == X_LAST) x_pixel_out = '0;
      if (y == '0 || y == Y_LAST) y_pixel_out = '0;
`endif
    end
  end

endmodule

// File: tb/tb_image_gradient.sv
// Randomized and directed bench for image_gradient (8x8, 8-bit) against a
// behavioural gradient model computed directly from the image array.
module tb_image_gradient;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] rd_addr, xw_addr, yw_addr;
  logic       rd_vld, xw_vld, yw_vld, busy, done;
  logic [7:0] pix_in = 8'h00;
  logic [7:0] xo, yo;
  logic [7:0] rd_p1 = 8'h00;

  logic [7:0] img [N];
  logic [7:0] gx_obs [N];
  logic [7:0] gy_obs [N];
  int n_checks = 0;
  int n_fail   = 0;

  image_gradient #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .img_read_addr(rd_addr), .img_read_addr_valid(rd_vld), .img_pixel_in(pix_in),
    .x_write_addr(xw_addr), .y_write_addr(yw_addr),
    .x_pixel_out(xo), .y_pixel_out(yo),
    .x_write_valid(xw_vld), .y_write_valid(yw_vld),
    .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;

  // Source BRAM: word appears two cycles after the address is presented
  always @(posedge clk) begin
    rd_p1  <= img[rd_addr];
    pix_in <= rd_p1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int px, input int py);
    int cx, cy;
    cx = (px < 0) ? 0 : (px > W - 1) ? W - 1 : px;
    cy = (py < 0) ? 0 : (py > H - 1) ? H - 1 : py;
    return int'(img[cx + cy * W]);
  endfunction

  // floor(d/2) wrapped to 8 bits
  function automatic logic [7:0] half(input int d);
    int q;
    q = (d >= 0) ? d / 2 : -((1 - d) / 2);
    return q[7:0];
  endfunction

  function automatic logic [7:0] exp_gx(input int px, input int py);
`ifndef GRADIENT_EDGE_CLAMP_EN
    if (px == 0 || px == W - 1) return 8'h00;
`endif
    return half(pix(px + 1, py) - pix(px - 1, py));
  endfunction

  function automatic logic [7:0] exp_gy(input int px, input int py);
`ifndef GRADIENT_EDGE_CLAMP_EN
    if (py == 0 || py == H - 1) return 8'h00;
`endif
    return half(pix(px, py + 1) - pix(px, py - 1));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdvld"}, rd_vld, 0);
    check({tag, "_rdaddr"}, rd_addr, 0);
    check({tag, "_xvld"}, xw_vld, 0);
    check({tag, "_yvld"}, yw_vld, 0);
    check({tag, "_xaddr"}, xw_addr, 0);
    check({tag, "_yaddr"}, yw_addr, 0);
    check({tag, "_xo"}, xo, 0);
    check({tag, "_yo"}, yo, 0);
  endtask

  // Run one frame from a start pulse, checking every write against the model
  task automatic run_frame(input string tag, input bit extra_start);
    int nwr, done_cyc, extras;
    bit finished;
    nwr = 0; done_cyc = -1; extras = 0; finished = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_first_strobe"}, rd_vld, 1);
    for (int cyc = 0; cyc < 1200 && !finished; cyc++) begin
      if (extra_start) start = (cyc == 100);
      check({tag, "_excl"}, rd_vld & (xw_vld | yw_vld), 0);
      check({tag, "_pair"}, xw_vld, yw_vld);
      check({tag, "_busy"}, busy, !done);
      if (xw_vld) begin
        check({tag, "_xaddr"}, xw_addr, nwr[5:0]);
        check({tag, "_yaddr"}, yw_addr, nwr[5:0]);
        check({tag, "_gx"}, xo, exp_gx(nwr % W, nwr / W));
        check({tag, "_gy"}, yo, exp_gy(nwr % W, nwr / W));
        if (nwr < N) begin
          gx_obs[nwr] = xo;
          gy_obs[nwr] = yo;
        end
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        finished = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, 832);
    check({tag, "_writes"}, nwr, N);
    for (int i = 0; i < 20; i++) begin
      if (xw_vld || yw_vld || rd_vld || done || busy) extras++;
      @(negedge clk);
    end
    check({tag, "_quiet"}, extras, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) img[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // Constant image: all gradients zero, 832-cycle frame
    for (int i = 0; i < N; i++) img[i] = 8'h5A;
    run_frame("const", 0);

    // Ramp 2x: interior x-gradient 2, borders 1 (clamped) or 0
    for (int i = 0; i < N; i++) img[i] = 8'((i % W) * 2);
    run_frame("ramp", 0);
    check("ramp_interior", gx_obs[3], 8'h02);
`ifdef GRADIENT_EDGE_CLAMP_EN
    check("ramp_left", gx_obs[8], 8'h01);
    check("ramp_right", gx_obs[15], 8'h01);
`else
    check("ramp_left", gx_obs[8], 8'h00);
    check("ramp_right", gx_obs[15], 8'h00);
`endif
    check("ramp_gy", gy_obs[27], 8'h00);

    // Random image with extreme neighbours planted around (3,3) and (5,5); extra start mid-frame
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    img[2 + 3 * W] = 8'd255; img[4 + 3 * W] = 8'd0;
    img[3 + 2 * W] = 8'd0;   img[3 + 4 * W] = 8'd255;
    img[4 + 5 * W] = 8'd0;   img[6 + 5 * W] = 8'd255;
    img[5 + 4 * W] = 8'd255; img[5 + 6 * W] = 8'd0;
    run_frame("rand", 1);
    check("ext_gx_neg", gx_obs[27], 8'h80);
    check("ext_gy_pos", gy_obs[27], 8'h7F);
    check("ext_gx_pos", gx_obs[45], 8'h7F);
    check("ext_gy_neg", gy_obs[45], 8'h80);

    // Reset during pixel 20, then a clean restart
    begin
      int nwr, late;
      nwr = 0; late = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int cyc = 0; cyc < 400 && nwr < 20; cyc++) begin
        if (xw_vld) nwr++;
        @(negedge clk);
      end
      check("abort_reached", nwr, 20);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("abort");
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 60; i++) begin
        if (xw_vld || yw_vld || done) late++;
        @(negedge clk);
      end
      check("abort_no_writes", late, 0);
    end
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    run_frame("restart", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_gradient.md
IMAGE_GRADIENT -- requirements
Module: image_gradient

Interface
REQ-001 SHALL have parameter WIDTH, default 64: image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 64: image height in pixels.
REQ-003 SHALL have parameter BIT_DEPTH, default 8: pixel and gradient word width.
REQ-004 SHALL have port clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start_in, input, 1: one-cycle pulse that starts a full-frame pass.
REQ-007 SHALL have port img_read_addr, output, $clog2(WIDTH*HEIGHT): source image BRAM address.
REQ-008 SHALL have port img_read_addr_valid, output, 1: one-cycle read strobe.
REQ-009 SHALL have port img_pixel_in, input, BIT_DEPTH: unsigned source pixel, valid 2 cycles after the strobe.
REQ-010 SHALL have ports x_write_addr and y_write_addr, output, $clog2(WIDTH*HEIGHT) each: gradient BRAM write addresses.
REQ-011 SHALL have ports x_pixel_out and y_pixel_out, output, BIT_DEPTH each: two's-complement gradients.
REQ-012 SHALL have ports x_write_valid and y_write_valid, output, 1 each: one-cycle write enables.
REQ-013 SHALL have port busy_out, output, 1: high from the cycle after an accepted start through the final write.
REQ-014 SHALL have port done_out, output, 1: one-cycle pulse at frame completion.

Function
REQ-015 SHALL visit pixels in raster order: x=0..WIDTH-1 inner, y=0..HEIGHT-1 outer, address = x + y*WIDTH.
REQ-016 SHALL use states IDLE, READ_L, READ_R, READ_U, READ_D, WRITE, DONE.
REQ-017 IDLE SHALL move to READ_L on start_in; start_in SHALL be ignored in all other states.
REQ-018 Each READ state SHALL last exactly 3 cycles: strobe in cycle 0, capture img_pixel_in in cycle 2, then advance L->R->U->D->WRITE.
REQ-019 Neighbour addresses SHALL be (x-1,y), (x+1,y), (x,y-1), (x,y+1), with an out-of-range coordinate clamped to the nearest edge.
REQ-020 The difference SHALL be computed at BIT_DEPTH+1 bits as R-L (x) and D-U (y), arithmetically shifted right 1 and truncated to BIT_DEPTH; the result always fits (-2^(B-1)..2^(B-1)-1).
REQ-021 WRITE SHALL last 1 cycle and assert x_write_valid and y_write_valid together, with both addresses set to the centre address.
REQ-022 WRITE SHALL go to READ_L for the next pixel, or to DONE after pixel WIDTH*HEIGHT-1.
REQ-023 DONE SHALL last 1 cycle, assert done_out, deassert busy_out and return to IDLE.
REQ-024 Each pixel SHALL take exactly 13 cycles; a frame SHALL take WIDTH*HEIGHT*13 cycles from the first READ_L cycle to the last WRITE cycle inclusive.
REQ-025 Strobes SHALL never overlap: at most one of img_read_addr_valid or the write pair is high in any cycle.

Reset
REQ-026 When rst_in=0 at a clock edge: state SHALL be IDLE, all valid/strobe outputs, busy_out and done_out SHALL be 0, and all addresses, data outputs and the pixel counter SHALL be 0.
REQ-027 Reset mid-frame SHALL abort immediately, with no further writes; the next start_in SHALL restart from pixel 0.

Configuration
REQ-028 Macro GRADIENT_EDGE_CLAMP_EN: when defined, border pixels SHALL use clamped neighbours (REQ-019).
REQ-029 Without GRADIENT_EDGE_CLAMP_EN: x_pixel_out SHALL be 0 for x=0 or x=WIDTH-1, and y_pixel_out SHALL be 0 for y=0 or y=HEIGHT-1; all reads and cycle timing SHALL be unchanged.

Verification (WIDTH=HEIGHT=8, BIT_DEPTH=8)
REQ-030 Constant image 0x5A, start -> 64 writes of x=0x00, y=0x00; done_out 832 cycles after the first READ_L cycle.
REQ-031 Ramp pixel=2x, macro defined -> x=0x02 at interior, x=0x01 at x=0 and x=7, y=0x00 everywhere; macro undefined -> x=0x00 at x=0 and x=7.
REQ-032 Interior pixel with L=255, R=0 -> x_pixel_out=0x80; with L=0, R=255 -> x_pixel_out=0x7F; same check for U/D on y.
REQ-033 start_in pulsed again mid-frame -> ignored; exactly 64 writes and one done_out.
REQ-034 rst_in=0 during pixel 20 -> no writes after reset; a new start rewrites addresses 0..63 in order.
